// File: rtl/axis_tuple_packer.sv
// Packs C_ITEM_WIDTH tuples from a FWFT FIFO into C_AXIS_TDATA_WIDTH AXI4-Stream beats with tkeep/tlast.
// Optional macro PACKER_SENTINEL_PAD_EN: pad the final partial beat with all-ones tuples and full tkeep.
module axis_tuple_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ITEM_WIDTH       = 128,
  parameter int C_COUNT_WIDTH      = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  input  logic                            cfg_start,
  input  logic [C_COUNT_WIDTH-1:0]        cfg_total_items,
  output logic                            busy,
  output logic                            done,
  input  logic                            item_valid,
  input  logic [C_ITEM_WIDTH-1:0]         item_data,
  output logic                            item_deq,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);
  localparam int N  = C_AXIS_TDATA_WIDTH / C_ITEM_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int LB = C_ITEM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, PACK, SEND, FIN} state_t;

  state_t                   state;
  logic [C_COUNT_WIDTH-1:0] remaining;
  logic [IW-1:0]            lane;
  logic [KW-1:0]            keep_f;
  logic                     last_item;

  assign item_deq  = (state == PACK) && item_valid;
  assign last_item = (remaining == C_COUNT_WIDTH'(1));

  // Byte enables for a beat whose highest filled lane is the one being written now.
  always_comb begin
    keep_f = '0;
    for (int k = 0; k < N; k++) begin
`ifdef PACKER_SENTINEL_PAD_EN
      keep_f[k*LB +: LB] = '1;
`else
      if (k <= int'(lane)) keep_f[k*LB +: LB] = '1;
`endif
    end
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state         <= IDLE;
      remaining     <= '0;
      lane          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle still belongs to the finishing run, so starts are refused there.
          if (cfg_start && !done) begin
            remaining <= cfg_total_items;
            busy      <= 1'b1;
            lane      <= '0;
            state     <= (cfg_total_items == '0) ? FIN : PACK;
          end
        end
        PACK: begin
          if (item_valid) begin
            m_axis_tdata[int'(lane)*C_ITEM_WIDTH +: C_ITEM_WIDTH] <= item_data;
            remaining <= remaining - C_COUNT_WIDTH'(1);
            lane      <= lane + IW'(1);
            if (lane == IW'(N-1) || last_item) begin
              state         <= SEND;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= last_item;
              m_axis_tkeep  <= keep_f;
`ifdef PACKER_SENTINEL_PAD_EN
              for (int k = 0; k < N; k++)
                if (k > int'(lane)) m_axis_tdata[k*C_ITEM_WIDTH +: C_ITEM_WIDTH] <= '1;
`endif
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
            lane          <= '0;
            state         <= (remaining == '0) ? FIN : PACK;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axis_tuple_packer.md
Name: axis_tuple_packer

Overview:
- Transmit-side counterpart of the per-channel AXI read unpacker.
- Drains fixed-width merged tuples (P keys, P*32 = 128 bits) from the merger output FIFO and packs them into 512-bit AXI4-Stream beats.
- Emits tkeep on the final partial beat and asserts tlast after a programmed tuple count.
- Sits between the merger-tree output IFIFO16 and the m_axis write path of the merger kernel.

Parameters:
C_AXIS_TDATA_WIDTH, 512, output stream data width in bits
C_ITEM_WIDTH, 128, width of one tuple; must divide C_AXIS_TDATA_WIDTH and be a multiple of 8
C_COUNT_WIDTH, 32, width of the tuple-count configuration and internal counters

Ports:
m_axis_aclk  input  1  single clock for the whole block
m_axis_areset  input  1  reset, asynchronous, active-high
cfg_start  input  1  one-cycle pulse; latches cfg_total_items and starts a run
cfg_total_items  input  C_COUNT_WIDTH  number of tuples in the run
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the run's last beat handshakes (or immediately for a zero count)
item_valid  input  1  source FIFO not empty (first-word-fall-through)
item_data  input  C_ITEM_WIDTH  head tuple of source FIFO
item_deq  output  1  pops one tuple this cycle
m_axis_tvalid  output  1  AXIS valid
m_axis_tready  input  1  AXIS ready
m_axis_tdata  output  C_AXIS_TDATA_WIDTH  packed beat
m_axis_tkeep  output  C_AXIS_TDATA_WIDTH/8  byte enables
m_axis_tlast  output  1  final beat of run

Behaviour:
- N = C_AXIS_TDATA_WIDTH/C_ITEM_WIDTH lanes per beat (4 by default). Tuple k of a beat occupies bits [k*C_ITEM_WIDTH +: C_ITEM_WIDTH]; lane 0 is the first tuple taken.
- Reset (async assert, sync release): state IDLE. All outputs 0: busy, done, item_deq, tvalid, tdata, tkeep, tlast. Lane index, remaining count and any partial beat are discarded.
- FSM states IDLE, PACK, SEND, FIN.
- IDLE:
  - On cfg_start, latch remaining = cfg_total_items and assert busy.
  - Count 0: go to FIN; no beat is emitted.
  - Otherwise: go to PACK.
- PACK:
  - item_deq = item_valid (combinational); tuple written into the current lane on the same edge.
  - Lane index increments; remaining decrements per deq.
  - Go to SEND on the edge that fills lane N-1 or consumes the last tuple (remaining 1->0).
  - No deq when item_valid = 0; no bubbles inserted otherwise.
- SEND:
  - tvalid = 1; tdata, tkeep and tlast are held stable until tready.
  - item_deq = 0.
  - On handshake: clear lanes and index. Go to FIN if remaining = 0, else to PACK.
- Latency: with item_valid held high from the start, tvalid rises N cycles after the first deq. Peak throughput is N tuples per N+1 cycles.
- tkeep:
  - All ones for full beats.
  - Partial final beat with f filled lanes: low f*C_ITEM_WIDTH/8 bits set; unused lanes' tdata = 0.
- tlast = 1 only on the beat that carries the last tuple of the run.
- FIN: done = 1 for one cycle, busy = 0, return to IDLE.
- cfg_start while busy is ignored; the latched count is unaffected.
- cfg_start in the same cycle as done (FIN) is ignored; a start is accepted only in IDLE.
- Counter width: remaining is C_COUNT_WIDTH; the maximum count 2^C_COUNT_WIDTH-1 needs no wrap handling.
- Reset asserted mid-run: beat dropped, tvalid deasserts immediately (asynchronous), no done pulse.

Optional Feature:
- Macro PACKER_SENTINEL_PAD_EN.
- When defined:
  - Unused lanes of the final partial beat are filled with all-ones tuples (max-key sentinel).
  - tkeep is all ones on every beat, so downstream merge stages see a full beat.
  - Run length in tuples becomes ceil(count/N)*N on the wire.
- When undefined: zero padding with partial tkeep as specified above.

Test Plan:
- count=8, item_valid constant, tready=1, tuples 0..7 -> 2 beats. Beat0 lanes = 0,1,2,3 with tlast=0; beat1 lanes = 4,5,6,7 with tlast=1. tkeep all ones; done one cycle after beat1 handshake.
- count=6 -> beat1 holds lanes 4,5 with tkeep=0x0000_0000_FFFF_FFFF and upper 256 bits 0, tlast=1. With PACKER_SENTINEL_PAD_EN: upper lanes all ones and tkeep all ones.
- count=4, tready=0 for 10 cycles -> tvalid held with tdata stable. item_deq=0 throughout; single handshake on the first tready cycle.
- count=0 -> no tvalid, done pulses 2 cycles after cfg_start, busy high exactly 1 cycle.
- item_valid toggling every other cycle with count=5 -> exactly 5 deqs, no deq while item_valid=0. Beats: lanes 0..3, then lane 4 with tkeep=0xFFFF and tlast=1.
- Reset asserted while in SEND with count=12 -> all outputs 0 on the same cycle. After release plus a new cfg_start with count=4, one clean beat is emitted with tlast=1.
